neuron_sum_seq: RTL and testbench

- Serial, time-multiplexed replacement for the flat combinational sum-and-bias neuron.
- Accepts NUM_NEURON input activations one per beat over a valid/ready stream and accumulates them in a single BIT_WIDTH adder.
- Adds the bias latched at start and presents the result on a valid/ready output.
- Sits between the weight-multiply stage and the activation stage of a layer; one instance per neuron, sequenced by the layer controller via start/busy.

---
 rtl/neuron_sum_seq_if.sv | 31 +++
 rtl/neuron_sum_seq.sv | 93 +++++++++
 tb/tb_neuron_sum_seq.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/neuron_sum_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | neuron_sum_seq_if : start/bias, input stream, result stream and status   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface neuron_sum_seq_if #(
  parameter int BIT_WIDTH = 8,
  parameter int CNT_W     = 10
);
  logic                 start;
  logic [BIT_WIDTH-1:0] b;
  logic                 in_valid;
  logic                 in_ready;
  logic [BIT_WIDTH-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [BIT_WIDTH-1:0] out_data;
  logic                 busy;
  logic [CNT_W-1:0]     beat_cnt;

  modport master (
    output start, b, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, beat_cnt
  );

  modport slave (
    input  start, b, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, beat_cnt
  );
endinterface
`default_nettype wire

// File: rtl/neuron_sum_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | neuron_sum_seq : serial sum of NUM_NEURON activation beats plus bias     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module neuron_sum_seq #(
  parameter int BIT_WIDTH  = 8,
  parameter int NUM_NEURON = 784,
  parameter int CNT_W      = $clog2(NUM_NEURON + 1)
) (
  input  wire                    clk,
  input  wire                    rst,
  neuron_sum_seq_if.slave        bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_BIAS  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(NUM_NEURON - 1);

  state_t               state_q, state_d;
  logic [BIT_WIDTH-1:0] acc_q, acc_d;
  logic [BIT_WIDTH-1:0] bias_q, bias_d;
  logic [BIT_WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    bias_d     = bias_q;
    out_data_d = out_data_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          bias_d  = bus.b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        // in_ready is high for the whole state, so in_valid alone marks a transfer
        if (bus.in_valid) begin
          acc_d = acc_q + bus.in_data;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == C_LAST_BEAT) begin
            state_d = S_BIAS;
          end
        end
      end
      S_BIAS: begin
        acc_d      = acc_q + bias_q;
        out_data_d = acc_q + bias_q;
        state_d    = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      bias_q     <= '0;
      out_data_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      bias_q     <= bias_d;
      out_data_q <= out_data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == S_ACCUM);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_data  = out_data_q;
  assign bus.beat_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_neuron_sum_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_neuron_sum_seq : directed and random operations on N=4 and N=1 units  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_neuron_sum_seq;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] beats4 [4];

  neuron_sum_seq_if #(.BIT_WIDTH(8), .CNT_W(3)) bus4 ();
  neuron_sum_seq_if #(.BIT_WIDTH(8), .CNT_W(1)) bus1 ();

  neuron_sum_seq #(.BIT_WIDTH(8), .NUM_NEURON(4), .CNT_W(3)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  neuron_sum_seq #(.BIT_WIDTH(8), .NUM_NEURON(1), .CNT_W(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference result: plain integer sum of the beats and bias, reduced mod 256
  function automatic logic [7:0] ref_sum(input logic [7:0] bias);
    int s;
    s = bias;
    for (int i = 0; i < 4; i++) s += beats4[i];
    return 8'(s % 256);
  endfunction

  // One operation on the N=4 unit using beats4; bubble_pct = chance of a gap
  task automatic op4(input logic [7:0] bias, input int bubble_pct, input int stall,
                     input bit chk_lat);
    logic [7:0] exp;
    int         edges;
    int         idx;
    int         guard;
    bit         v;
    exp = ref_sum(bias);
    bus4.start = 1'b1;
    bus4.b     = bias;
    bus4.out_ready = 1'b0;
    step();
    edges = 1;
    bus4.start = 1'b0;
    bus4.b     = 8'($urandom);
    check("accum_busy", 32'(bus4.busy), 1);
    check("accum_ready", 32'(bus4.in_ready), 1);
    check("accum_cnt0", 32'(bus4.beat_cnt), 0);
    idx   = 0;
    guard = 0;
    while (idx < 4 && guard < 200) begin
      v = ($urandom_range(99) >= 32'(bubble_pct));
      bus4.in_valid = v;
      bus4.in_data  = v ? beats4[idx] : 8'($urandom);
      bus4.start    = 1'($urandom_range(1));
      step();
      edges++;
      guard++;
      if (v) idx++;
      check("beat_cnt", 32'(bus4.beat_cnt), 32'(idx));
    end
    if (guard >= 200) check("beat_timeout", 0, 1);
    bus4.in_valid = 1'b1;
    bus4.in_data  = 8'($urandom);
    check("bias_no_ready", 32'(bus4.in_ready), 0);
    check("bias_no_valid", 32'(bus4.out_valid), 0);
    step();
    edges++;
    if (chk_lat) check("latency_edges", 32'(edges), 6);
    check("done_valid", 32'(bus4.out_valid), 1);
    check("done_data", 32'(bus4.out_data), 32'(exp));
    check("done_cnt", 32'(bus4.beat_cnt), 4);
    for (int s = 0; s < stall; s++) begin
      bus4.start = 1'($urandom_range(1));
      step();
      check("stall_valid", 32'(bus4.out_valid), 1);
      check("stall_data", 32'(bus4.out_data), 32'(exp));
    end
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    bus4.start     = 1'b1;
    step();
    check("exit_busy", 32'(bus4.busy), 0);
    check("exit_valid", 32'(bus4.out_valid), 0);
    check("exit_hold_data", 32'(bus4.out_data), 32'(exp));
    bus4.start     = 1'b0;
    bus4.out_ready = 1'b0;
    step();
    check("no_restart", 32'(bus4.busy), 0);
    check("idle_ready", 32'(bus4.in_ready), 0);
  endtask

  initial begin
    int edges1;
    rst = 1'b1;
    bus4.start = 1'b0; bus4.b = '0; bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.out_ready = 1'b0;
    bus1.start = 1'b0; bus1.b = '0; bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
    step();
    step();
    check("rst_busy", 32'(bus4.busy), 0);
    check("rst_ready", 32'(bus4.in_ready), 0);
    check("rst_valid", 32'(bus4.out_valid), 0);
    check("rst_data", 32'(bus4.out_data), 0);
    check("rst_cnt", 32'(bus4.beat_cnt), 0);
    check("rst1_busy", 32'(bus1.busy), 0);
    rst = 1'b0;
    bus4.in_valid = 1'b1;
    step();
    check("idle_ignores_valid", 32'(bus4.beat_cnt), 0);
    bus4.in_valid = 1'b0;

    // b=5, beats 1..4 back-to-back, latency check
    beats4 = '{8'd1, 8'd2, 8'd3, 8'd4};
    op4(8'd5, 0, 0, 1'b1);
    // wrap-around
    beats4 = '{8'd200, 8'd100, 8'd0, 8'd0};
    op4(8'd10, 0, 0, 1'b1);
    // bubbles
    beats4 = '{8'd1, 8'd2, 8'd3, 8'd4};
    op4(8'd0, 50, 0, 1'b0);
    // result 15 held for 5 stalled cycles
    op4(8'd5, 0, 5, 1'b1);

    // reset mid-ACCUM after 2 beats
    bus4.start = 1'b1; bus4.b = 8'd99;
    step();
    bus4.start = 1'b0;
    bus4.in_valid = 1'b1; bus4.in_data = 8'd7;
    step();
    step();
    check("pre_rst_cnt", 32'(bus4.beat_cnt), 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus4.in_valid = 1'b0;
    check("mid_rst_busy", 32'(bus4.busy), 0);
    check("mid_rst_ready", 32'(bus4.in_ready), 0);
    check("mid_rst_cnt", 32'(bus4.beat_cnt), 0);
    check("mid_rst_valid", 32'(bus4.out_valid), 0);
    beats4 = '{8'd1, 8'd1, 8'd1, 8'd1};
    op4(8'd1, 0, 0, 1'b1);

    // randomized operations
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 4; i++) beats4[i] = 8'($urandom);
      op4(8'($urandom), int'($urandom_range(60)), int'($urandom_range(3)), 1'b0);
    end

    // NUM_NEURON=1 unit
    bus1.start = 1'b1; bus1.b = 8'd7;
    step();
    edges1 = 1;
    bus1.start = 1'b0; bus1.b = 8'd50;
    bus1.in_valid = 1'b1; bus1.in_data = 8'd9;
    step();
    edges1++;
    check("n1_cnt", 32'(bus1.beat_cnt), 1);
    check("n1_bias_no_valid", 32'(bus1.out_valid), 0);
    check("n1_bias_no_ready", 32'(bus1.in_ready), 0);
    bus1.in_valid = 1'b0;
    step();
    edges1++;
    check("n1_latency", 32'(edges1), 3);
    check("n1_valid", 32'(bus1.out_valid), 1);
    check("n1_data", 32'(bus1.out_data), 16);
    bus1.out_ready = 1'b1;
    step();
    bus1.out_ready = 1'b0;
    check("n1_exit_busy", 32'(bus1.busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
